// File: rtl/matrix_printer.sv
// Reads a stored matrix row-major and streams it as ASCII decimal text
// (space between columns, CR LF per row) over a valid/ready byte port.
//
// state      | meaning
// S_IDLE     | waiting for start; latched request and indices held
// S_CHECK    | one cycle to sample the selected slot-valid flag
// S_RD_REQ   | rd_en high for this single cycle
// S_RD_WAIT  | waiting for rd_elem_valid, bounded by timer_q
// S_SEND_DIG | presenting decimal digits, most significant first
// S_SEND_SEP | presenting the column separator (space)
// S_SEND_CR  | presenting carriage return
// S_SEND_LF  | presenting line feed
// S_DONE     | done pulse, back to idle
module matrix_printer #(
  parameter int MAX_DIM    = 5,
  parameter int ELEM_WIDTH = 8,
  parameter int DIM_BITS   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [3:0]            m,
  input  logic [3:0]            n,
  input  logic                  slot_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [3:0]            query_m,
  output logic [3:0]            query_n,
  input  logic                  query_slot0_valid,
  input  logic                  query_slot1_valid,
  output logic                  rd_en,
  output logic [3:0]            rd_m,
  output logic [3:0]            rd_n,
  output logic                  rd_slot_idx,
  output logic [DIM_BITS-1:0]   rd_row_idx,
  output logic [DIM_BITS-1:0]   rd_col_idx,
  input  logic [ELEM_WIDTH-1:0] rd_elem,
  input  logic                  rd_elem_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_RD_REQ, S_RD_WAIT, S_SEND_DIG,
    S_SEND_SEP, S_SEND_CR, S_SEND_LF, S_DONE
  } state_t;

  localparam logic [3:0] MAX_DIM_L = 4'(MAX_DIM);

  state_t                state_q;
  logic                  busy_q, done_q, err_q, rd_en_q, tx_valid_q;
  logic [3:0]            m_q, n_q;
  logic                  slot_q;
  logic [DIM_BITS-1:0]   row_q, col_q;
  logic [ELEM_WIDTH-1:0] elem_q;
  logic [1:0]            dig_q;
  logic [1:0]            timer_q;
  logic [7:0]            tx_data_q;

  // Digit index: 0 = hundreds, 1 = tens, 2 = ones.
  function automatic logic [3:0] dec_digit(input logic [ELEM_WIDTH-1:0] v,
                                           input logic [1:0] idx);
    case (idx)
      2'd0:    return 4'(v / ELEM_WIDTH'(100));
      2'd1:    return 4'((v / ELEM_WIDTH'(10)) % ELEM_WIDTH'(10));
      default: return 4'(v % ELEM_WIDTH'(10));
    endcase
  endfunction

  function automatic logic [1:0] first_dig(input logic [ELEM_WIDTH-1:0] v);
    if (v >= ELEM_WIDTH'(100)) return 2'd0;
    else if (v >= ELEM_WIDTH'(10)) return 2'd1;
    else return 2'd2;
  endfunction

  function automatic logic [7:0] ascii(input logic [ELEM_WIDTH-1:0] v,
                                       input logic [1:0] idx);
    return 8'h30 + {4'h0, dec_digit(v, idx)};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_en_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      m_q        <= '0;
      n_q        <= '0;
      slot_q     <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      elem_q     <= '0;
      dig_q      <= '0;
      timer_q    <= '0;
    end else begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_en_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          m_q    <= m;
          n_q    <= n;
          slot_q <= slot_idx;
          row_q  <= '0;
          col_q  <= '0;
          if (m == 4'd0 || m > MAX_DIM_L || n == 4'd0 || n > MAX_DIM_L) begin
            err_q <= 1'b1;
          end else begin
            busy_q  <= 1'b1;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (slot_q ? query_slot1_valid : query_slot0_valid) begin
            rd_en_q <= 1'b1;
            state_q <= S_RD_REQ;
          end else begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_RD_REQ: begin
          // Four wait cycles after the rd_en cycle before giving up.
          timer_q <= 2'd3;
          state_q <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (rd_elem_valid) begin
            elem_q     <= rd_elem;
            dig_q      <= first_dig(rd_elem);
            tx_data_q  <= ascii(rd_elem, first_dig(rd_elem));
            tx_valid_q <= 1'b1;
            state_q    <= S_SEND_DIG;
          end else if (timer_q == 2'd0) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            timer_q <= timer_q - 2'd1;
          end
        end
        S_SEND_DIG: if (tx_ready) begin
          if (dig_q == 2'd2) begin
            if (4'(col_q) < n_q - 4'd1) begin
              tx_data_q <= 8'h20;
              state_q   <= S_SEND_SEP;
            end else begin
              tx_data_q <= 8'h0D;
              state_q   <= S_SEND_CR;
            end
          end else begin
            dig_q     <= dig_q + 2'd1;
            tx_data_q <= ascii(elem_q, dig_q + 2'd1);
          end
        end
        S_SEND_SEP: if (tx_ready) begin
          tx_valid_q <= 1'b0;
          col_q      <= col_q + 1'b1;
          rd_en_q    <= 1'b1;
          state_q    <= S_RD_REQ;
        end
        S_SEND_CR: if (tx_ready) begin
          tx_data_q <= 8'h0A;
          state_q   <= S_SEND_LF;
        end
        S_SEND_LF: if (tx_ready) begin
          tx_valid_q <= 1'b0;
          if (4'(row_q) < m_q - 4'd1) begin
            row_q   <= row_q + 1'b1;
            col_q   <= '0;
            rd_en_q <= 1'b1;
            state_q <= S_RD_REQ;
          end else begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign query_m     = m_q;
  assign query_n     = n_q;
  assign rd_en       = rd_en_q;
  assign rd_m        = m_q;
  assign rd_n        = n_q;
  assign rd_slot_idx = slot_q;
  assign rd_row_idx  = row_q;
  assign rd_col_idx  = col_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;

endmodule

// File: tb/tb_matrix_printer.sv
// Directed bench for matrix_printer: behavioural storage read port, byte
// collector with hold checks, and hand-computed expected text streams.
module tb_matrix_printer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] m, n;
  logic       slot_idx;
  logic       busy, done, err;
  logic [3:0] query_m, query_n;
  logic       q0v, q1v;
  logic       rd_en;
  logic [3:0] rd_m, rd_n;
  logic       rd_slot_idx;
  logic [2:0] rd_row_idx, rd_col_idx;
  logic [7:0] rd_elem = 8'h00;
  logic       rd_elem_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;

  always #5 clk = ~clk;

  matrix_printer dut (
    .clk(clk), .rst(rst), .start(start), .m(m), .n(n), .slot_idx(slot_idx),
    .busy(busy), .done(done), .err(err),
    .query_m(query_m), .query_n(query_n),
    .query_slot0_valid(q0v), .query_slot1_valid(q1v),
    .rd_en(rd_en), .rd_m(rd_m), .rd_n(rd_n), .rd_slot_idx(rd_slot_idx),
    .rd_row_idx(rd_row_idx), .rd_col_idx(rd_col_idx),
    .rd_elem(rd_elem), .rd_elem_valid(rd_elem_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] mem [0:1][0:7][0:7];
  bit         stuck    = 1'b0;
  int         rdy_mode = 0;

  int         cyc = 0;
  int         rd_rises = 0, done_cnt = 0, err_cnt = 0, busy_cnt = 0, tx_cnt = 0;
  int         hold_viol = 0, both_viol = 0, rd_en_cyc = 0, err_cyc = 0;
  logic       rd_en_d = 1'b0;
  bit         pend = 1'b0;
  logic [7:0] pend_data = 8'h00;
  logic [7:0] rx_q[$];

  // Storage read port model plus output monitors.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rd_elem_valid <= 1'b0;
    if (!rst) begin
      rd_en_d <= 1'b0;
      pend    <= 1'b0;
    end else begin
      rd_en_d <= rd_en;
      if (rd_en && !rd_en_d) begin
        rd_rises  <= rd_rises + 1;
        rd_en_cyc <= cyc;
        if (!stuck) begin
          rd_elem_valid <= 1'b1;
          rd_elem       <= mem[rd_slot_idx][rd_row_idx][rd_col_idx];
        end
      end
      if (tx_valid && tx_ready) rx_q.push_back(tx_data);
      if (tx_valid) tx_cnt <= tx_cnt + 1;
      if (busy) busy_cnt <= busy_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (err) begin
        err_cnt <= err_cnt + 1;
        err_cyc <= cyc;
      end
      if (done && err) both_viol <= both_viol + 1;
      if (pend && (!tx_valid || tx_data !== pend_data)) hold_viol <= hold_viol + 1;
      pend      <= tx_valid && !tx_ready;
      pend_data <= tx_data;
    end
  end

  always @(negedge clk) tx_ready = (rdy_mode == 0) || (cyc % 3 == 0);

  task automatic run_print(input logic [3:0] mm, input logic [3:0] nn, input logic s,
                           input bit inject, input int budget, output int lat);
    @(negedge clk);
    m = mm; n = nn; slot_idx = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!(done || err) && lat < budget) begin
      if (inject && lat == 3) begin
        m = 4'd5; n = 4'd5; slot_idx = 1'b1; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    chk("print_ends", {31'd0, done | err}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_bytes(input string tag, input int base, input logic [7:0] exp[$]);
    chk({tag, "_len"}, rx_q.size() - base, exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("%s_b%0d", tag, i),
          (base + i < rx_q.size()) ? {24'd0, rx_q[base + i]} : 32'hDEAD, {24'd0, exp[i]});
  endtask

  task automatic build_exp(input int s, input int mm, input int nn, output logic [7:0] q[$]);
    string txt;
    q = {};
    for (int r = 0; r < mm; r++)
      for (int c = 0; c < nn; c++) begin
        txt = $sformatf("%0d", mem[s][r][c]);
        for (int k = 0; k < txt.len(); k++) q.push_back(txt[k]);
        if (c < nn - 1) q.push_back(8'h20);
        else begin
          q.push_back(8'h0D);
          q.push_back(8'h0A);
        end
      end
  endtask

  initial begin
    logic [7:0] exp1[$];
    logic [7:0] exp5[$];
    int lat, b_rx, b_done, b_err, b_rd, b_tx, b_busy;

    exp1 = '{8'h31, 8'h20, 8'h32, 8'h33, 8'h0D, 8'h0A,
             8'h31, 8'h30, 8'h30, 8'h20, 8'h30, 8'h0D, 8'h0A};
    for (int s = 0; s < 2; s++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) mem[s][r][c] = 8'd0;
    mem[0][0][0] = 8'd1;   mem[0][0][1] = 8'd23;
    mem[0][1][0] = 8'd100; mem[0][1][1] = 8'd0;

    rst = 1'b0; start = 1'b0; m = 4'd0; n = 4'd0; slot_idx = 1'b0;
    q0v = 1'b1; q1v = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", {27'd0, busy, done, err, rd_en, tx_valid}, 32'd0);
    chk("rst_dat", {10'd0, tx_data, query_m, query_n, rd_row_idx, rd_col_idx}, 32'd0);
    chk("rst_rd", {23'd0, rd_m, rd_n, rd_slot_idx}, 32'd0);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);

    // 2x2 print, with an ignored start while busy
    b_rx = rx_q.size(); b_done = done_cnt; b_err = err_cnt; b_rd = rd_rises;
    run_print(4'd2, 4'd2, 1'b0, 1'b1, 500, lat);
    check_bytes("t1", b_rx, exp1);
    chk("t1_done", done_cnt - b_done, 1);
    chk("t1_err", err_cnt - b_err, 0);
    chk("t1_rdrise", rd_rises - b_rd, 4);
    chk("t1_latch", {16'd0, query_m, query_n, rd_m, rd_n}, 32'h2222);
    chk("t1_busy", {31'd0, busy}, 0);

    // Same print with tx_ready asserted one cycle in three
    rdy_mode = 1;
    b_rx = rx_q.size(); b_done = done_cnt; b_err = err_cnt; b_rd = rd_rises;
    run_print(4'd2, 4'd2, 1'b0, 1'b0, 500, lat);
    check_bytes("t2", b_rx, exp1);
    chk("t2_done", done_cnt - b_done, 1);
    chk("t2_err", err_cnt - b_err, 0);
    chk("t2_rdrise", rd_rises - b_rd, 4);
    rdy_mode = 0;

    // Invalid slot
    b_tx = tx_cnt; b_err = err_cnt; b_rd = rd_rises; b_done = done_cnt;
    run_print(4'd3, 4'd1, 1'b1, 1'b0, 20, lat);
    chk("t3_lat", lat, 2);
    chk("t3_err", err_cnt - b_err, 1);
    chk("t3_done", done_cnt - b_done, 0);
    chk("t3_tx", tx_cnt - b_tx, 0);
    chk("t3_rd", rd_rises - b_rd, 0);

    // Illegal dimensions
    b_err = err_cnt; b_busy = busy_cnt; b_rd = rd_rises;
    run_print(4'd0, 4'd4, 1'b0, 1'b0, 20, lat);
    chk("t4a_lat", lat, 1);
    run_print(4'd6, 4'd2, 1'b0, 1'b0, 20, lat);
    chk("t4b_lat", lat, 1);
    chk("t4_err", err_cnt - b_err, 2);
    chk("t4_busy", busy_cnt - b_busy, 0);
    chk("t4_rd", rd_rises - b_rd, 0);

    // 5x5 all-255: reset after the tenth byte, then a full restart
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) mem[0][r][c] = 8'd255;
    b_rx = rx_q.size(); b_done = done_cnt; b_err = err_cnt;
    @(negedge clk);
    m = 4'd5; n = 4'd5; slot_idx = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (rx_q.size() - b_rx >= 10) break;
      @(posedge clk); #1;
    end
    chk("t5_tenth", rx_q.size() - b_rx, 10);
    rst = 1'b0;
    #1;
    chk("t5_rst_ctl", {27'd0, busy, done, err, rd_en, tx_valid}, 32'd0);
    chk("t5_rst_dat", {10'd0, tx_data, query_m, query_n, rd_row_idx, rd_col_idx}, 32'd0);
    chk("t5_rst_rd", {23'd0, rd_m, rd_n, rd_slot_idx}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_no_pulse", (done_cnt - b_done) + (err_cnt - b_err), 0);
    build_exp(0, 5, 5, exp5);
    b_rx = rx_q.size(); b_done = done_cnt;
    run_print(4'd5, 4'd5, 1'b0, 1'b0, 3000, lat);
    check_bytes("t5", b_rx, exp5);
    chk("t5_done", done_cnt - b_done, 1);

    // Read data never arrives
    stuck = 1'b1;
    b_err = err_cnt; b_done = done_cnt; b_tx = tx_cnt; b_rd = rd_rises;
    run_print(4'd1, 4'd1, 1'b0, 1'b0, 50, lat);
    chk("t6_err", err_cnt - b_err, 1);
    chk("t6_done", done_cnt - b_done, 0);
    chk("t6_rd", rd_rises - b_rd, 1);
    chk("t6_gap", err_cyc - rd_en_cyc, 5);
    chk("t6_tx", tx_cnt - b_tx, 0);
    chk("t6_busy", {31'd0, busy}, 0);
    stuck = 1'b0;

    chk("hold_stable", hold_viol, 0);
    chk("done_err_excl", both_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
